// File: rtl/reg_file_mp_pkg.sv
// Shared helpers for the multi-port register file: address-width math,
// byte-lane merging and parameter legality checking.
package reg_file_mp_pkg;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return w;
    endfunction

    // One byte lane of a byte-enabled write.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       be);
        return be ? new_byte : old_byte;
    endfunction

    function automatic bit params_ok(input int data_w, input int depth, input int num_rd);
        return (data_w >= 8) && (data_w % 8 == 0) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (num_rd >= 1);
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: picks the pre-edge or post-edge register value, masks
// register 0 when it is hardwired, and registers data plus a valid strobe.
module reg_file_rd_port
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int AW       = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    input  logic [DATA_W-1:0] arr_val,
    input  logic [DATA_W-1:0] byp_val,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic [DATA_W-1:0] sel_val;

    always_comb begin
        sel_val = BYPASS ? byp_val : arr_val;
        if (ZERO_REG && (rd_addr == '0)) begin
            sel_val = '0;
        end
    end

    // rd_en is a request that is always accepted (no ready); rd_valid
    // qualifies rd_data for exactly the cycle after the accepting edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= sel_val;
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: one byte-enabled write port, NUM_RD registered
// read ports, optional write-to-read bypass and optional hardwired zero reg.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int NUM_RD   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = clog2(DEPTH),
    localparam int NB      = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [NB-1:0]            wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid
);

    localparam bit PARAMS_OK = params_ok(DATA_W, DEPTH, NUM_RD);

    if (!PARAMS_OK) begin : g_param_check
        $error("reg_file_mp: illegal DATA_W/DEPTH/NUM_RD combination");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;
    logic              wr_ok;

    assign wr_ok = wr_en && !(ZERO_REG && (wr_addr == '0));

    always_comb begin
        merged = mem[wr_addr];
        for (int i = 0; i < NB; i++) begin
            merged[i*8 +: 8] = byte_merge(mem[wr_addr][i*8 +: 8], wr_data[i*8 +: 8], wr_be[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= merged;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] arr_val;
        logic [DATA_W-1:0] next_val;

        assign addr    = rd_addr[p*AW +: AW];
        assign arr_val = mem[addr];

        // Post-edge value of the addressed register, forwarded when BYPASS=1.
        always_comb begin
            next_val = arr_val;
            if (clr) begin
                next_val = '0;
            end else if (wr_ok && (wr_addr == addr)) begin
                next_val = merged;
            end
        end

        reg_file_rd_port #(
            .DATA_W  (DATA_W),
            .AW      (AW),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .rd_en   (rd_en[p]),
            .rd_addr (addr),
            .arr_val (arr_val),
            .byp_val (next_val),
            .rd_data (rd_data[p*DATA_W +: DATA_W]),
            .rd_valid(rd_valid[p])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypassing and a non-bypassing 32x4 instance share
// stimulus; a 64x16, 3-port, zero-register instance takes a long random run.
module tb_reg_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        clr_a, wr_en_a;
    logic [1:0]  wr_addr_a;
    logic [3:0]  wr_be_a;
    logic [31:0] wr_data_a;
    logic [1:0]  rd_en_a;
    logic [3:0]  rd_addr_a;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_valid_a, rd_valid_b;

    logic         clr_c, wr_en_c;
    logic [3:0]   wr_addr_c;
    logic [7:0]   wr_be_c;
    logic [63:0]  wr_data_c;
    logic [2:0]   rd_en_c;
    logic [11:0]  rd_addr_c;
    logic [191:0] rd_data_c;
    logic [2:0]   rd_valid_c;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: register contents and the expected registered outputs.
    logic [31:0] mem_a [4];
    logic [31:0] exp_a [2];
    logic [31:0] exp_b [2];
    logic [1:0]  expv_ab;
    logic [63:0] mem_c [16];
    logic [63:0] exp_c [3];
    logic [2:0]  expv_c;

    reg_file_mp #(.DATA_W(32), .DEPTH(4), .NUM_RD(2), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_be(wr_be_a), .wr_data(wr_data_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a));

    reg_file_mp #(.DATA_W(32), .DEPTH(4), .NUM_RD(2), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_be(wr_be_a), .wr_data(wr_data_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b));

    reg_file_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(3), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_c (
        .clk(clk), .rst(rst), .clr(clr_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
        .wr_be(wr_be_c), .wr_data(wr_data_c), .rd_en(rd_en_c), .rd_addr(rd_addr_c),
        .rd_data(rd_data_c), .rd_valid(rd_valid_c));

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem_a[i] = '0;
        for (int i = 0; i < 16; i++) mem_c[i] = '0;
        for (int p = 0; p < 2; p++) begin
            exp_a[p] = '0;
            exp_b[p] = '0;
        end
        for (int p = 0; p < 3; p++) exp_c[p] = '0;
        expv_ab = '0;
        expv_c  = '0;
    endtask

    // Drive one cycle on the 32-bit pair and advance the model past the edge.
    task automatic step_ab(input logic c, input logic we, input logic [1:0] wa,
                           input logic [3:0] be, input logic [31:0] wd,
                           input logic [1:0] ren, input logic [1:0] ra0, input logic [1:0] ra1);
        logic [31:0] pre [4];
        logic [1:0]  ra [2];
        clr_a = c; wr_en_a = we; wr_addr_a = wa; wr_be_a = be; wr_data_a = wd;
        rd_en_a = ren; rd_addr_a = {ra1, ra0};
        @(posedge clk);
        #1;
        pre = mem_a;
        if (c) begin
            for (int i = 0; i < 4; i++) mem_a[i] = '0;
        end else if (we) begin
            for (int i = 0; i < 4; i++) if (be[i]) mem_a[wa][i*8 +: 8] = wd[i*8 +: 8];
        end
        ra[0] = ra0;
        ra[1] = ra1;
        for (int p = 0; p < 2; p++) begin
            if (ren[p]) begin
                exp_a[p] = mem_a[ra[p]];
                exp_b[p] = pre[ra[p]];
            end
        end
        expv_ab = ren;
    endtask

    task automatic step_c(input logic c, input logic we, input logic [3:0] wa,
                          input logic [7:0] be, input logic [63:0] wd,
                          input logic [2:0] ren, input logic [11:0] ra);
        clr_c = c; wr_en_c = we; wr_addr_c = wa; wr_be_c = be; wr_data_c = wd;
        rd_en_c = ren; rd_addr_c = ra;
        @(posedge clk);
        #1;
        if (c) begin
            for (int i = 0; i < 16; i++) mem_c[i] = '0;
        end else if (we && wa != 4'd0) begin
            for (int i = 0; i < 8; i++) if (be[i]) mem_c[wa][i*8 +: 8] = wd[i*8 +: 8];
        end
        for (int p = 0; p < 3; p++) begin
            if (ren[p]) exp_c[p] = (ra[p*4 +: 4] == 4'd0) ? 64'd0 : mem_c[ra[p*4 +: 4]];
        end
        expv_c = ren;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clr_a = 0; wr_en_a = 0; wr_addr_a = 0; wr_be_a = 0; wr_data_a = 0; rd_en_a = 0; rd_addr_a = 0;
        clr_c = 0; wr_en_c = 0; wr_addr_c = 0; wr_be_c = 0; wr_data_c = 0; rd_en_c = 0; rd_addr_c = 0;
        model_reset();
        #12;
        n_cmp++;
        if (rd_data_a !== 64'd0 || rd_valid_a !== 2'b00 || rd_data_b !== 64'd0 ||
            rd_valid_b !== 2'b00 || rd_data_c !== 192'd0 || rd_valid_c !== 3'b000) begin
            n_err++;
            $display("FAIL reset_state: a=%h/%b b=%h/%b c_valid=%b required all zero",
                     rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, rd_valid_c);
        end
        #10 rst = 1'b1;
        for (int r = 0; r < 4; r++) step_ab(0, 1, r[1:0], 4'hF, 32'hDEADBEEF, 2'b00, 0, 0);
        step_ab(0, 0, 0, 4'h0, 32'h0, 2'b11, 2'd0, 2'd3);
        n_cmp++;
        if (rd_data_a !== {2{32'hDEADBEEF}} || rd_valid_a !== 2'b11) begin
            n_err++;
            $display("FAIL pre_reset_read: got %h/%b required %h/11", rd_data_a, rd_valid_a, {2{32'hDEADBEEF}});
        end
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (rd_data_a !== 64'd0 || rd_valid_a !== 2'b00 || rd_data_b !== 64'd0 || rd_valid_b !== 2'b00) begin
            n_err++;
            $display("FAIL async_reset: a=%h/%b b=%h/%b required zero", rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
        end
        model_reset();
        #2 rst = 1'b1;
        for (int r = 0; r < 4; r += 2) begin
            step_ab(0, 0, 0, 4'h0, 32'h0, 2'b11, r[1:0], r[1:0] + 2'd1);
            n_cmp++;
            if (rd_data_a !== 64'd0 || rd_valid_a !== 2'b11 || rd_data_b !== 64'd0) begin
                n_err++;
                $display("FAIL post_reset_read r%0d: a=%h/%b b=%h required 0/11", r, rd_data_a, rd_valid_a, rd_data_b);
            end
        end
    endtask

    task automatic test_clear();
        for (int r = 0; r < 4; r++) step_ab(0, 1, r[1:0], 4'hF, 32'hDEADBEEF, 2'b00, 0, 0);
        step_ab(0, 0, 0, 4'h0, 32'h0, 2'b11, 2'd1, 2'd2);
        step_ab(1, 0, 0, 4'h0, 32'h0, 2'b00, 0, 0);
        n_cmp++;
        if (rd_data_a !== {2{32'hDEADBEEF}} || rd_valid_a !== 2'b00) begin
            n_err++;
            $display("FAIL clr_keeps_rd_data: got %h/%b required %h/00", rd_data_a, rd_valid_a, {2{32'hDEADBEEF}});
        end
        for (int r = 0; r < 4; r += 2) begin
            step_ab(0, 0, 0, 4'h0, 32'h0, 2'b11, r[1:0], r[1:0] + 2'd1);
            n_cmp++;
            if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0 || rd_valid_b !== 2'b11) begin
                n_err++;
                $display("FAIL clear_read r%0d: a=%h b=%h/%b required 0/11", r, rd_data_a, rd_data_b, rd_valid_b);
            end
        end
    endtask

    task automatic test_byte_enable();
        step_ab(0, 1, 2'd2, 4'hF, 32'h11223344, 2'b00, 0, 0);
        step_ab(0, 1, 2'd2, 4'b0101, 32'hAABBCCDD, 2'b00, 0, 0);
        step_ab(0, 1, 2'd2, 4'b0000, 32'hFFFFFFFF, 2'b00, 0, 0);
        step_ab(0, 0, 0, 4'h0, 32'h0, 2'b11, 2'd2, 2'd2);
        n_cmp++;
        if (rd_data_a !== {2{32'h11BB33DD}} || rd_data_b !== {2{32'h11BB33DD}}) begin
            n_err++;
            $display("FAIL byte_enable: a=%h b=%h required %h", rd_data_a, rd_data_b, {2{32'h11BB33DD}});
        end
    endtask

    task automatic test_bypass();
        step_ab(0, 1, 2'd1, 4'hF, 32'h5, 2'b00, 0, 0);
        step_ab(0, 1, 2'd1, 4'hF, 32'h9, 2'b11, 2'd1, 2'd1);
        n_cmp++;
        if (rd_data_a !== {2{32'h9}} || rd_valid_a !== 2'b11) begin
            n_err++;
            $display("FAIL bypass_on: got %h/%b required %h/11", rd_data_a, rd_valid_a, {2{32'h9}});
        end
        n_cmp++;
        if (rd_data_b !== {2{32'h5}} || rd_valid_b !== 2'b11) begin
            n_err++;
            $display("FAIL bypass_off: got %h/%b required %h/11", rd_data_b, rd_valid_b, {2{32'h5}});
        end
    endtask

    task automatic test_clr_beats_write();
        step_ab(0, 1, 2'd3, 4'hF, 32'h1234, 2'b00, 0, 0);
        step_ab(1, 1, 2'd3, 4'hF, 32'h77, 2'b11, 2'd3, 2'd3);
        n_cmp++;
        if (rd_data_a !== 64'd0 || rd_data_b !== {2{32'h1234}}) begin
            n_err++;
            $display("FAIL clr_vs_write_same_cycle: a=%h b=%h required 0 and %h", rd_data_a, rd_data_b, {2{32'h1234}});
        end
        step_ab(0, 0, 0, 4'h0, 32'h0, 2'b01, 2'd3, 2'd0);
        n_cmp++;
        if (rd_data_a[31:0] !== 32'd0 || rd_data_b[31:0] !== 32'd0 || rd_valid_a !== 2'b01) begin
            n_err++;
            $display("FAIL clr_vs_write_after: a=%h/%b b=%h required 0/01", rd_data_a[31:0], rd_valid_a, rd_data_b[31:0]);
        end
    endtask

    task automatic test_random_ab(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            step_ab(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    4'($urandom), $urandom, 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (rd_data_a[p*32 +: 32] !== exp_a[p] || rd_data_b[p*32 +: 32] !== exp_b[p] ||
                    rd_valid_a[p] !== expv_ab[p] || rd_valid_b[p] !== expv_ab[p]) begin
                    n_err++;
                    $display("FAIL random_ab cyc%0d p%0d: a=%h/%b b=%h/%b required %h/%h/%b", n, p,
                             rd_data_a[p*32 +: 32], rd_valid_a[p], rd_data_b[p*32 +: 32], rd_valid_b[p],
                             exp_a[p], exp_b[p], expv_ab[p]);
                end
            end
        end
    endtask

    task automatic test_zero_reg();
        step_c(0, 1, 4'd0, 8'hFF, {64{1'b1}}, 3'b111, 12'h000);
        n_cmp++;
        if (rd_data_c !== 192'd0 || rd_valid_c !== 3'b111) begin
            n_err++;
            $display("FAIL zero_reg_same_cycle: got %h/%b required 0/111", rd_data_c, rd_valid_c);
        end
        step_c(0, 0, 4'd0, 8'h00, 64'd0, 3'b111, 12'h000);
        n_cmp++;
        if (rd_data_c !== 192'd0 || rd_valid_c !== 3'b111) begin
            n_err++;
            $display("FAIL zero_reg_next_cycle: got %h/%b required 0/111", rd_data_c, rd_valid_c);
        end
    endtask

    task automatic test_random_c(input int cycles);
        logic [3:0]  wa;
        logic [11:0] ra;
        for (int n = 0; n < cycles; n++) begin
            wa = 4'($urandom_range(0, 15));
            for (int p = 0; p < 3; p++) begin
                ra[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            end
            step_c(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), wa,
                   ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom},
                   3'($urandom_range(0, 7)), ra);
            for (int p = 0; p < 3; p++) begin
                n_cmp++;
                if (rd_data_c[p*64 +: 64] !== exp_c[p] || rd_valid_c[p] !== expv_c[p]) begin
                    n_err++;
                    $display("FAIL random_c cyc%0d p%0d: got %h/%b required %h/%b", n, p,
                             rd_data_c[p*64 +: 64], rd_valid_c[p], exp_c[p], expv_c[p]);
                end
            end
        end
    endtask

    task automatic test_hold();
        step_c(0, 1, 4'd7, 8'hFF, 64'h0123_4567_89AB_CDEF, 3'b000, 12'h000);
        step_c(0, 0, 4'd0, 8'h00, 64'd0, 3'b111, {4'd7, 4'd7, 4'd0});
        for (int n = 0; n < 5; n++) begin
            step_c(0, 1, 4'd7, 8'hFF, {$urandom, $urandom}, 3'b000, 12'($urandom));
            n_cmp++;
            if (rd_data_c !== {64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'd0} ||
                rd_valid_c !== 3'b000) begin
                n_err++;
                $display("FAIL hold cyc%0d: got %h/%b required held data/000", n, rd_data_c, rd_valid_c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_enable();
        test_bypass();
        test_clr_beats_write();
        test_random_ab(400);
        test_zero_reg();
        test_random_c(10000);
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file: the next generation of the 4×32, 2-read-port datapath register file. It generalises width, depth and read-port count, and adds byte-enable writes, an optional write-to-read bypass, an optional hardwired zero register, a synchronous clear and per-port read-valid strobes. It sits between the decode stage (read addresses) and writeback (write port) of the team's datapath.

## Interface
- DATA_W, 32, register width in bits; must be a multiple of 8.
- DEPTH, 4, number of registers; must be a power of 2 and ≥2; AW = log2(DEPTH).
- NUM_RD, 2, number of independent read ports; must be ≥1.
- BYPASS, 1, 1 = a same-cycle write is forwarded to reads; 0 = reads return the pre-write value.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of all registers.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- wr_data  in  DATA_W  write data.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD×AW  packed; port p uses bits [p×AW +: AW].
- rd_data  out  NUM_RD×DATA_W  packed, registered.
- rd_valid  out  NUM_RD  per-port strobe, high for the cycle after an accepted read.

## Operation
- Storage: DEPTH × DATA_W array.
- Reset (rst low) acts immediately, without waiting for a clock:
  - All registers = 0.
  - rd_data = 0.
  - rd_valid = 0.
- When rst is released, the first active edge is the first rising clk edge with rst high.
- Clear: clr high at an edge zeroes every register.
  - clr has priority over a write in the same cycle; that write is dropped.
- Write: wr_en high, clr low at an edge.
  - Each byte with wr_be[i] = 1 takes wr_data; bytes with wr_be[i] = 0 keep their value.
  - wr_be = 0 is a legal no-op.
- ZERO_REG = 1:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, including bypassed reads.
- Read, per port p: rd_en[p] high at an edge.
  - rd_data[p] loads the value of reg[rd_addr[p]].
  - rd_valid[p] = 1 for the next cycle.
  - With rd_en[p] low: rd_data[p] holds its last value and rd_valid[p] = 0.
- Bypass semantics (BYPASS = 1): the read result equals the register's post-edge value. This means:
  - A byte-merged same-cycle write to the same address is forwarded.
  - A same-cycle clr forwards 0.
- No bypass (BYPASS = 0): the read result is the register's pre-edge value.
- Read ports are fully independent:
  - Any ports may read the same address in the same cycle.
  - No arbitration and no back-pressure.

## Timing
- Read latency: exactly 1 cycle, from the address/enable edge to rd_data/rd_valid.
- Write latency: the array is updated at the sampling edge.
  - A read issued in the following cycle always sees the new value, for either BYPASS setting.
- Throughput: one write plus NUM_RD reads every cycle, sustained.
- Bypass path: write data → read register is combinational within the cycle.
  - Critical path = byte merge + NUM_RD read muxes.
- Reset mid-operation: rd_valid drops to 0 immediately; in-flight reads are lost.
- clr has no effect on rd_data/rd_valid of reads already registered.

## Structure
- Package reg_file_mp_pkg:
  - Function clog2 for AW.
  - Function byte_merge(old, new, be).
  - Parameter legality checks as constants/assertions: DATA_W%8, power-of-2 DEPTH, NUM_RD≥1.
- Sub-module reg_file_rd_port, one instance per port via generate:
  - Selects between the array value and the bypass value.
  - Applies the ZERO_REG masking.
  - Owns the rd_data/rd_valid flops.
- Top level owns the array, the clear/write logic, and computes the post-edge "next" value used for bypass.

## Test plan
- Reset/clear:
  - Write 0xDEADBEEF to all regs, assert rst low mid-cycle → rd_data = 0 and rd_valid = 0 immediately; all regs then read 0.
  - Repeat using clr → all regs read 0 the next cycle.
- Byte enables: reg2 = 0x11223344, then write 0xAABBCCDD with wr_be = 4'b0101 → reg2 reads 0x11BB33DD.
- Bypass (BYPASS = 1):
  - Reg1 = 0x5, same-cycle write 0x9 to reg1 and read reg1 on both ports → both rd_data = 0x9, both rd_valid = 1 one cycle later.
  - Same stimulus with BYPASS = 0 → 0x5.
- Clear beats write: clr = 1 with wr_en = 1 writing 0x77 to reg3 and a read of reg3 → returns 0 (BYPASS = 1); reg3 reads 0 afterwards.
- ZERO_REG = 1: write 0xFFFFFFFF to reg0, read reg0 in the same cycle and the next cycle → 0 both times.
- Parameter sweep: DATA_W = 64, DEPTH = 16, NUM_RD = 3.
  - Random writes/reads for 10k cycles against a reference model, zero mismatches.
  - Hold check: rd_en low for 5 cycles → rd_data unchanged, rd_valid = 0.
